// File: rtl/uart_rx.sv
// 8N1 serial receiver with oversampled mid-bit sampling, a two-flop input synchronizer and break handling.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_parity_err,
    output logic       rx_busy
);

    localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SAMP_W   = $clog2(OVERSAMPLE);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    logic              rx_meta_q;
    logic              rx_s_q;
    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick;

    state_t            state_q,  state_d;
    logic [SAMP_W-1:0] samp_q,   samp_d;
    logic [2:0]        bit_q,    bit_d;
    logic [7:0]        shift_q,  shift_d;
    logic [7:0]        data_q,   data_d;
    logic              valid_q,  valid_d;
    logic              ferr_q,   ferr_d;
`ifdef UART_RX_PARITY_EN
    logic              perr_q,   perr_d;
    logic              par_bad_q, par_bad_d;
`endif

    // Synchronizer flops reset to the idle level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
        end
    end

    assign tick = (tick_cnt_q == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            samp_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            samp_q    <= samp_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        samp_d    = samp_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d    = 1'b0;
        par_bad_d = par_bad_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    samp_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (samp_q == SAMP_MID) begin
                        if (rx_s_q) begin
                            state_d = S_IDLE;
                        end else begin
                            samp_d  = '0;
                            bit_d   = '0;
                            state_d = S_DATA;
                        end
                    end else begin
                        samp_d = samp_q + SAMP_W'(1);
                    end
                end
            end
            // From here on every sample point sits one full bit after the previous mid-bit.
            S_DATA: begin
                if (tick) begin
                    if (samp_q == SAMP_LAST) begin
                        samp_d  = '0;
                        shift_d = {rx_s_q, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end else begin
                        samp_d = samp_q + SAMP_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    if (samp_q == SAMP_LAST) begin
                        samp_d    = '0;
                        par_bad_d = ^{shift_q, rx_s_q};
                        state_d   = S_STOP;
                    end else begin
                        samp_d = samp_q + SAMP_W'(1);
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (samp_q == SAMP_LAST) begin
                        samp_d = '0;
`ifdef UART_RX_PARITY_EN
                        perr_d = par_bad_q;
                        if (rx_s_q) begin
                            if (!par_bad_q) begin
                                data_d  = shift_q;
                                valid_d = 1'b1;
                            end
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_BREAK;
                        end
`else
                        if (rx_s_q) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_BREAK;
                        end
`endif
                    end else begin
                        samp_d = samp_q + SAMP_W'(1);
                    end
                end
            end
            // A line held low must return high before another start bit is accepted.
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = perr_q;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: reset, single frame, back-to-back frames, glitch, framing error, reset mid-frame.
// Scaled-down clock/baud so a bit period is 48 clocks (TICK_DIV = 3, OVERSAMPLE = 16).
module tb_uart_rx;

    localparam int CLK_FREQ   = 480;
    localparam int BAUD_RATE  = 10;
    localparam int OVERSAMPLE = 16;
    localparam int TICK_DIV   = 3;
    localparam int BIT_CLKS   = TICK_DIV * OVERSAMPLE;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       rx_busy;

    int n_run  = 0;
    int n_fail = 0;

    int cyc       = 0;
    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int perr_cnt  = 0;
    int both_cnt  = 0;
    int busy_cnt  = 0;
    logic [7:0] vdata_q[$];
    int         vcyc_q[$];

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_parity_err(rx_parity_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt <= valid_cnt + 1;
            vdata_q.push_back(rx_data);
            vcyc_q.push_back(cyc);
        end
        if (rx_frame_err)             ferr_cnt <= ferr_cnt + 1;
        if (rx_parity_err)            perr_cnt <= perr_cnt + 1;
        if (rx_valid && rx_frame_err) both_cnt <= both_cnt + 1;
        if (rx_busy)                  busy_cnt <= busy_cnt + 1;
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par !== ^b) rx = 1'b1;
`endif
        drive_bit(stop);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        int b_v, b_f, b_b;
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        n_run++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", rx_data); end
        n_run++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        n_run++; if (rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", rx_frame_err); end
        n_run++; if (rx_parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", rx_parity_err); end
        n_run++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
        rst_n = 1'b1;
        @(negedge clk);
        b_v = valid_cnt; b_f = ferr_cnt; b_b = busy_cnt;
        repeat (2 * FRAME_BITS * BIT_CLKS) @(negedge clk);
        n_run++; if (valid_cnt - b_v != 0) begin n_fail++; $display("FAIL idle_valid: got %0d pulses want 0", valid_cnt - b_v); end
        n_run++; if (ferr_cnt - b_f != 0) begin n_fail++; $display("FAIL idle_ferr: got %0d pulses want 0", ferr_cnt - b_f); end
        n_run++; if (busy_cnt - b_b != 0) begin n_fail++; $display("FAIL idle_busy: got %0d busy cycles want 0", busy_cnt - b_b); end
        n_run++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL idle_data: got %h want 00", rx_data); end
    endtask

    task automatic test_single();
        int b_v, b_f, b_p, b_b, t0, lat;
        b_v = valid_cnt; b_f = ferr_cnt; b_p = perr_cnt; b_b = busy_cnt;
        t0 = cyc;
        send_frame(8'hA5, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        n_run++; if (valid_cnt - b_v != 1) begin n_fail++; $display("FAIL single_count: got %0d pulses want 1", valid_cnt - b_v); end
        if (valid_cnt - b_v >= 1) begin
            n_run++; if (vdata_q[b_v] !== 8'hA5) begin n_fail++; $display("FAIL single_pulse_data: got %h want a5", vdata_q[b_v]); end
            lat = vcyc_q[b_v] - t0;
            n_run++; if (lat < 456 || lat > 460) begin n_fail++; $display("FAIL single_latency: got %0d clks want 456..460", lat); end
        end
        n_run++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", rx_data); end
        n_run++; if (ferr_cnt - b_f != 0 || perr_cnt - b_p != 0) begin n_fail++; $display("FAIL single_errs: got ferr %0d perr %0d want 0 0", ferr_cnt - b_f, perr_cnt - b_p); end
        n_run++; if (busy_cnt - b_b < 9 * BIT_CLKS) begin n_fail++; $display("FAIL single_busy_seen: got %0d busy cycles want >= %0d", busy_cnt - b_b, 9 * BIT_CLKS); end
        n_run++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", rx_busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        int b_v, b_f;
        exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h55;
        b_v = valid_cnt; b_f = ferr_cnt;
        for (int i = 0; i < 3; i++) send_frame(exp[i], ^exp[i], 1'b1);
        repeat (8) @(negedge clk);
        n_run++; if (valid_cnt - b_v != 3) begin n_fail++; $display("FAIL b2b_count: got %0d pulses want 3", valid_cnt - b_v); end
        for (int i = 0; i < 3; i++) begin
            if (valid_cnt - b_v > i) begin
                n_run++; if (vdata_q[b_v + i] !== exp[i]) begin n_fail++; $display("FAIL b2b_data%0d: got %h want %h", i, vdata_q[b_v + i], exp[i]); end
            end
        end
        n_run++; if (ferr_cnt - b_f != 0) begin n_fail++; $display("FAIL b2b_ferr: got %0d pulses want 0", ferr_cnt - b_f); end
    endtask

    task automatic test_glitch();
        int b_v, b_f, b_b;
        b_v = valid_cnt; b_f = ferr_cnt; b_b = busy_cnt;
        rx = 1'b0;
        repeat (3 * TICK_DIV) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        n_run++; if (valid_cnt - b_v != 0 || ferr_cnt - b_f != 0) begin n_fail++; $display("FAIL glitch_pulses: got valid %0d ferr %0d want 0 0", valid_cnt - b_v, ferr_cnt - b_f); end
        n_run++; if (busy_cnt - b_b == 0) begin n_fail++; $display("FAIL glitch_busy_seen: got 0 busy cycles want >0"); end
        n_run++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end: got %b want 0", rx_busy); end
        b_v = valid_cnt;
        send_frame(8'h81, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        n_run++; if (valid_cnt - b_v != 1 || rx_data !== 8'h81) begin n_fail++; $display("FAIL glitch_recover: got %0d pulses data %h want 1 81", valid_cnt - b_v, rx_data); end
    endtask

    task automatic test_frame_err();
        int b_v, b_f, b_p;
        send_frame(8'h81, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        b_v = valid_cnt; b_f = ferr_cnt; b_p = perr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (3 * FRAME_BITS * BIT_CLKS) @(negedge clk);
        n_run++; if (ferr_cnt - b_f != 1) begin n_fail++; $display("FAIL ferr_count: got %0d pulses want 1", ferr_cnt - b_f); end
        n_run++; if (valid_cnt - b_v != 0) begin n_fail++; $display("FAIL ferr_valid: got %0d pulses want 0", valid_cnt - b_v); end
        n_run++; if (rx_data !== 8'h81) begin n_fail++; $display("FAIL ferr_data_held: got %h want 81", rx_data); end
        n_run++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_break: got %b want 1", rx_busy); end
        n_run++; if (perr_cnt - b_p != 0) begin n_fail++; $display("FAIL ferr_perr: got %0d pulses want 0", perr_cnt - b_p); end
        rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        n_run++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_end: got %b want 0", rx_busy); end
        n_run++; if (ferr_cnt - b_f != 1 || valid_cnt - b_v != 0) begin n_fail++; $display("FAIL ferr_after_release: got ferr %0d valid %0d want 1 0", ferr_cnt - b_f, valid_cnt - b_v); end
        n_run++; if (both_cnt != 0) begin n_fail++; $display("FAIL valid_and_ferr_together: got %0d cycles want 0", both_cnt); end
    endtask

    task automatic test_reset_mid();
        int b_v, b_f;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rst_n = 1'b0;
        #1;
        n_run++; if (rx_busy !== 1'b0 || rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_clear: got busy %b data %h want 0 00", rx_busy, rx_data); end
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        b_v = valid_cnt; b_f = ferr_cnt;
        repeat (FRAME_BITS * BIT_CLKS) @(negedge clk);
        n_run++; if (valid_cnt - b_v != 0 || ferr_cnt - b_f != 0 || rx_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet: got valid %0d ferr %0d busy %b want 0 0 0", valid_cnt - b_v, ferr_cnt - b_f, rx_busy); end
        send_frame(8'h5A, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        n_run++; if (valid_cnt - b_v != 1 || rx_data !== 8'h5A) begin n_fail++; $display("FAIL rstmid_restart: got %0d pulses data %h want 1 5a", valid_cnt - b_v, rx_data); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int b_v, b_p;
        b_v = valid_cnt; b_p = perr_cnt;
        send_frame(8'h07, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        n_run++; if (perr_cnt - b_p != 1 || valid_cnt - b_v != 0) begin n_fail++; $display("FAIL parity_bad: got perr %0d valid %0d want 1 0", perr_cnt - b_p, valid_cnt - b_v); end
        n_run++; if (rx_data !== 8'h5A) begin n_fail++; $display("FAIL parity_bad_data: got %h want 5a", rx_data); end
        b_v = valid_cnt; b_p = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        n_run++; if (perr_cnt - b_p != 0 || valid_cnt - b_v != 1 || rx_data !== 8'h07) begin n_fail++; $display("FAIL parity_good: got perr %0d valid %0d data %h want 0 1 07", perr_cnt - b_p, valid_cnt - b_v, rx_data); end
    endtask
`else
    task automatic test_parity();
        n_run++; if (perr_cnt != 0) begin n_fail++; $display("FAIL parity_tied: got %0d pulses want 0", perr_cnt); end
    endtask
`endif

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rx    = 1'b1;
        rst_n = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver; the downstream counterpart of the team's UART transmitter.
- Recovers 8N1 frames from an asynchronous serial line using an oversampled baud tick.
- Delivers each byte to the fabric as a one-cycle valid pulse with error flags.
- Loops back directly against the transmitter when both use the same CLK_FREQ/BAUD_RATE.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bits/s.
- OVERSAMPLE, 16, sample ticks per bit period; must be even and at least 8.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line; asynchronous to clk; idles high.
- rx_data  output  8  last received byte; LSB was received first.
- rx_valid  output  1  one-cycle pulse: rx_data holds a good frame.
- rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- rx_parity_err  output  1  one-cycle pulse: parity mismatch. Tied 0 without the macro.
- rx_busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - rx_data = 8'h00; rx_valid, rx_frame_err, rx_parity_err, rx_busy = 0.
  - Both synchronizer flops = 1; state = IDLE; all counters = 0.
- Input synchronizer: two-flop synchronizer on rx; all logic uses the synchronized value rx_s.
- Tick generator:
  - TICK_DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer truncation; 325 at defaults.
  - Free-running counter 0..TICK_DIV-1; issues a one-cycle tick at the wrap.
  - Counter width = $clog2(TICK_DIV).
- Sample counter: counts ticks 0..OVERSAMPLE-1 within each bit.
- Bit counter: 3 bits.
- State machine:
  - IDLE: rx_busy = 0. On rx_s == 0 (the falling edge), clear the sample counter and go to START; rx_busy = 1 from the next cycle.
  - START: at sample count OVERSAMPLE/2-1 (mid start bit), check rx_s.
    - rx_s == 1: false start; go to IDLE. No pulse on any output.
    - rx_s == 0: clear the sample counter and bit counter; go to DATA.
  - DATA: at sample count OVERSAMPLE-1 (mid bit), shift rx_s into shift_reg[7] with a right shift, so the byte assembles LSB first.
    - After the 8th bit (bit counter == 7), go to STOP, or to PARITY when PARITY_EN is defined.
  - STOP: at mid stop bit, check rx_s.
    - rx_s == 1: load rx_data from shift_reg and pulse rx_valid for one cycle; go to IDLE.
    - rx_s == 0: rx_data is not updated; pulse rx_frame_err for one cycle; go to BREAK.
  - BREAK: wait until rx_s == 1, then go to IDLE. This stops a held-low line from producing repeated frames.
- Latency: rx_valid asserts on the clk edge after the tick that samples mid stop bit. That is about 9.5 bit periods after the rx falling edge, plus 2-3 clk cycles of synchronizer delay.
- rx_valid and rx_frame_err are never high in the same cycle.
- rx_data holds its value until the next valid frame.
- Back-to-back frames: a new start bit may begin immediately after the stop-bit midpoint. IDLE must detect it with no lost frame.
- No backpressure: the consumer must take rx_data within one frame time. Overrun is not flagged.
- Reset mid-frame: all state clears immediately, with no pulses. After reset release, reception restarts at the next falling edge.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP that samples one even-parity bit at mid bit.
  - Computed parity = XOR of the 8 data bits plus the received parity bit; a result of 1 is a mismatch.
  - On mismatch, rx_parity_err pulses together with the outcome of STOP (the rx_valid or rx_frame_err cycle). rx_valid is suppressed and rx_data is not updated.
  - Frame length becomes 11 bits.
- Not defined: no PARITY state; rx_parity_err is constant 0; frame is 8N1.

Test Plan:
- Reset, rx held high for 2 frame times -> rx_valid = 0, rx_busy = 0, rx_data = 8'h00.
- Loopback from the transmitter at defaults, send 8'hA5 -> exactly one rx_valid pulse with rx_data = 8'hA5 and no error pulses.
- Back-to-back 8'h00, 8'hFF, 8'h55 with no idle gap -> three rx_valid pulses in order with matching data.
- rx low glitch of 3 bit-ticks (shorter than half a bit) -> no rx_valid; rx_busy returns to 0; state back to IDLE.
- Frame 8'h3C with stop bit forced 0, then line held low for 3 frame times -> exactly one rx_frame_err pulse, rx_data unchanged, no further pulses until rx returns high.
- With UART_RX_PARITY_EN: byte 8'h07 with parity bit 0 (wrong) -> rx_parity_err pulse, no rx_valid. With parity bit 1 -> rx_valid, rx_data = 8'h07.
